// File: rtl/conv_out_requant_pool.sv
// Conv post-processing: ReLU, rounded requant to int8, then 2x2 stride-2 max pool.
// Build option LEAKY_RELU_EN: negative sums take a x>>>3 slope instead of clamping to zero.
module conv_out_requant_pool #(
    parameter int IMG_W   = 52,
    parameter int IMG_H   = 52,
    parameter int SHIFT_W = 5
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [23:0]        in_data,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               frame_done
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBN = IMG_W / 2;
    localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

    // pixel position counters and latched shift
    logic [CW-1:0]      col_q, col_d, pix_col;
    logic [RW-1:0]      row_q, row_d, pix_row;
    logic [SHIFT_W-1:0] shift_q, shift_d, eff_shift;

    // requant datapath
    logic signed [23:0] din;
    logic signed [24:0] relu_v, rnd_v, sum_v, shr_v;
    logic signed [7:0]  q_sat;

    // stage 1
    logic               s1_valid_q;
    logic signed [7:0]  s1_data_q;
    logic               s1_odd_col_q;
    logic               s1_odd_row_q;
    logic [LBW-1:0]     s1_idx_q;
    logic               s1_last_q;

    // stage 2
    logic signed [7:0]  hold_q;
    logic signed [7:0]  h_max;
    logic               s2_valid_q;
    logic signed [7:0]  s2_h_q;
    logic signed [7:0]  s2_lb_q;
    logic               s2_last_q;

    // stage 3
    logic               out_valid_q;
    logic signed [7:0]  out_data_q;
    logic               frame_done_q;

    logic signed [7:0]  lb_q [LBN];

    // A start-of-frame pixel is placed at (0,0) in the same cycle and uses the new shift.
    always_comb begin
        pix_col   = in_sof ? '0 : col_q;
        pix_row   = in_sof ? '0 : row_q;
        eff_shift = in_sof ? shift : shift_q;
        col_d     = col_q;
        row_d     = row_q;
        shift_d   = shift_q;
        if (in_valid) begin
            shift_d = eff_shift;
            if (pix_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (pix_row == RW'(IMG_H - 1)) ? '0 : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
        end
    end

    always_comb begin
        din    = signed'(in_data);
        relu_v = {din[23], din};
`ifdef LEAKY_RELU_EN
        if (din[23]) relu_v = relu_v >>> 3;
`else
        if (din[23]) relu_v = '0;
`endif
        rnd_v = '0;
        if (eff_shift != '0) rnd_v = 25'(1) << (eff_shift - 1'b1);
        sum_v = relu_v + rnd_v;
        shr_v = sum_v >>> eff_shift;
        if (shr_v > 25'sd127)       q_sat = 8'sd127;
        else if (shr_v < -25'sd128) q_sat = -8'sd128;
        else                        q_sat = shr_v[7:0];
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            shift_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_odd_col_q <= 1'b0;
            s1_odd_row_q <= 1'b0;
            s1_idx_q     <= '0;
            s1_last_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            shift_q    <= shift_d;
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q    <= q_sat;
                s1_odd_col_q <= pix_col[0];
                s1_odd_row_q <= pix_row[0];
                s1_idx_q     <= LBW'(pix_col >> 1);
                s1_last_q    <= (pix_col == CW'(IMG_W - 1)) && (pix_row == RW'(IMG_H - 1));
            end
        end
    end

    // A restart always lands on an even column, so any half-built pair is simply overwritten.
    assign h_max = (s1_data_q > hold_q) ? s1_data_q : hold_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            hold_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_h_q     <= '0;
            s2_lb_q    <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q & s1_odd_col_q & s1_odd_row_q;
            if (s1_valid_q) begin
                if (!s1_odd_col_q) begin
                    hold_q <= s1_data_q;
                end else if (s1_odd_row_q) begin
                    s2_h_q    <= h_max;
                    s2_lb_q   <= lb_q[s1_idx_q];
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (s1_valid_q && s1_odd_col_q && !s1_odd_row_q) lb_q[s1_idx_q] <= h_max;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= s2_valid_q;
            frame_done_q <= s2_valid_q & s2_last_q;
            if (s2_valid_q) out_data_q <= (s2_lb_q > s2_h_q) ? s2_lb_q : s2_h_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_out_requant_pool.sv
// Self-checking bench for conv_out_requant_pool: 2x2, 4x4 and 6x4 instances against a reference model.
module tb_conv_out_requant_pool;
    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        v2 = 1'b0, v4 = 1'b0, v6 = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] in_data = '0;
    logic [4:0]  shift = '0;
    logic        ov2, ov4, ov6, fd2, fd4, fd6;
    logic [7:0]  od2, od4, od6;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stray = 0;
    int in_cyc[$];
    int q2d[$], q4d[$], q6d[$];
    int q2c[$], q4c[$], q6c[$];
    bit q2f[$], q4f[$], q6f[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    conv_out_requant_pool #(.IMG_W(2), .IMG_H(2), .SHIFT_W(5)) u2 (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_valid(v2), .in_sof(in_sof), .in_data(in_data),
        .shift(shift), .out_valid(ov2), .out_data(od2), .frame_done(fd2));
    conv_out_requant_pool #(.IMG_W(4), .IMG_H(4), .SHIFT_W(5)) u4 (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_valid(v4), .in_sof(in_sof), .in_data(in_data),
        .shift(shift), .out_valid(ov4), .out_data(od4), .frame_done(fd4));
    conv_out_requant_pool #(.IMG_W(6), .IMG_H(4), .SHIFT_W(5)) u6 (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_valid(v6), .in_sof(in_sof), .in_data(in_data),
        .shift(shift), .out_valid(ov6), .out_data(od6), .frame_done(fd6));

    always @(negedge sclk) begin
        if (ov2) begin q2d.push_back(int'($signed(od2))); q2f.push_back(fd2); q2c.push_back(cyc); end
        if (ov4) begin q4d.push_back(int'($signed(od4))); q4f.push_back(fd4); q4c.push_back(cyc); end
        if (ov6) begin q6d.push_back(int'($signed(od6))); q6f.push_back(fd6); q6c.push_back(cyc); end
        if ((fd2 && !ov2) || (fd4 && !ov4) || (fd6 && !ov6)) stray <= stray + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-half-up division by 2^sh, done as floor((2v + 2^sh) / 2^(sh+1)).
    function automatic longint floordiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int rq(int x, int sh);
        longint v, p, r;
`ifdef LEAKY_RELU_EN
        v = (x < 0) ? floordiv(longint'(x), 8) : longint'(x);
`else
        v = (x < 0) ? 0 : longint'(x);
`endif
        p = 1;
        repeat (sh) p = p * 2;
        r = floordiv(2 * v + p, 2 * p);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic model_pool(input int d[$], input int w, input int h, input int sh, output int e[$]);
        int m, r;
        e.delete();
        for (int wy = 0; wy < h / 2; wy++) begin
            for (int wx = 0; wx < w / 2; wx++) begin
                m = -1000;
                for (int k = 0; k < 4; k++) begin
                    r = rq(d[(2 * wy + k / 2) * w + 2 * wx + k % 2], sh);
                    if (r > m) m = r;
                end
                e.push_back(m);
            end
        end
    endtask

    task automatic clearq();
        q2d.delete(); q4d.delete(); q6d.delete();
        q2f.delete(); q4f.delete(); q6f.delete();
        q2c.delete(); q4c.delete(); q6c.delete();
        in_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge sclk); #1; end
    endtask

    task automatic px(input int sel, input int data, input bit sof);
        in_data = data[23:0];
        in_sof  = sof;
        case (sel)
            0: v2 = 1'b1;
            1: v4 = 1'b1;
            default: v6 = 1'b1;
        endcase
        in_cyc.push_back(cyc);
        @(posedge sclk); #1;
        v2 = 1'b0; v4 = 1'b0; v6 = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int d[$], input bit sof, input int gapmax);
        for (int i = 0; i < d.size(); i++) begin
            if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
            px(sel, d[i], sof && (i == 0));
        end
    endtask

    task automatic check_outs(input string tag, input int sel, input int e[$]);
        int d[$];
        bit f[$];
        case (sel)
            0: begin d = q2d; f = q2f; end
            1: begin d = q4d; f = q4f; end
            default: begin d = q6d; f = q6f; end
        endcase
        chk({tag, "_count"}, d.size(), e.size());
        for (int i = 0; i < e.size() && i < d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), d[i], e[i]);
            chk($sformatf("%s_fd%0d", tag, i), int'(f[i]), (i == e.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int d[$], d2[$], e[$];
        int sh1, sh2;
        int t3_sh[5]  = '{0, 0, 23, 23, 23};
        int t3_px[5]  = '{127, 128, 4194304, 4194303, 4194304};
        int t3_exp[5] = '{127, 127, 1, 0, 1};

        // reset state
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_ov2", ov2, 0);   chk("rst_od4", od4, 0);
        chk("rst_fd6", fd6, 0);   chk("rst_ov6", ov6, 0);
        s_rst_n = 1'b1;
        idle(2);

        // requant / saturate on 2x2
        clearq(); shift = 5'd4;
        d = '{1000, 5000, -200, 0};
        send_frame(0, d, 1'b1, 0);
        idle(6);
        e = '{127};
        check_outs("t1", 0, e);
        chk("t1_lat", (q2c.size() > 0) ? q2c[0] : -1, in_cyc[3] + 3);

        // 4x4 pooling
        clearq(); shift = 5'd4;
        d = '{16, 32, 48, 64, 80, 0, -16, 160, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1, d, 1'b1, 0);
        idle(6);
        e = '{5, 10, 0, 0};
        check_outs("t2", 1, e);
        chk("t2_lat0", (q4c.size() > 0) ? q4c[0] : -1, in_cyc[5] + 3);
        chk("t2_lat3", (q4c.size() > 3) ? q4c[3] : -1, in_cyc[15] + 3);

        // rounding edges; shift pin is moved after sof to prove it is latched
        for (int k = 0; k < 5; k++) begin
            clearq(); shift = t3_sh[k][4:0];
            px(0, (k == 4) ? 0 : t3_px[k], 1'b1);
            shift = 5'd7;
            px(0, (k == 4) ? t3_px[k] : 0, 1'b0);
            px(0, 0, 1'b0);
            px(0, 0, 1'b0);
            idle(5);
            e = '{t3_exp[k]};
            check_outs($sformatf("t3_%0d", k), 0, e);
        end

        // negative sums: clamp to 0, or -100 -> -6 in the leaky build
        clearq(); shift = 5'd4;
        d = '{-800, -800, -800, -800};
        send_frame(0, d, 1'b1, 0);
        idle(5);
`ifdef LEAKY_RELU_EN
        e = '{-6};
`else
        e = '{0};
`endif
        check_outs("t_neg", 0, e);

        // sof at row1 col1 aborts the old frame
        clearq(); shift = 5'd4;
        for (int i = 0; i < 5; i++) px(1, 2000, i == 0);
        d.delete();
        for (int i = 0; i < 16; i++) d.push_back(int'($urandom_range(0, 3500)) - 500);
        send_frame(1, d, 1'b1, 0);
        idle(6);
        model_pool(d, 4, 4, 4, e);
        check_outs("t4", 1, e);
        chk("t4_lat", (q4c.size() > 0) ? q4c[0] : -1, in_cyc[10] + 3);

        // random 6x4 frames: gap-free, gapped, then a frame relying on counter wrap
        sh1 = int'($urandom_range(0, 10));
        sh2 = int'($urandom_range(0, 10));
        d.delete(); d2.delete();
        for (int i = 0; i < 24; i++) begin
            d.push_back(int'($urandom_range(0, 80000)) - 40000);
            d2.push_back(int'($urandom_range(0, 80000)) - 40000);
        end
        clearq(); shift = sh1[4:0];
        send_frame(2, d, 1'b1, 0);
        idle(6);
        model_pool(d, 6, 4, sh1, e);
        check_outs("t5a", 2, e);
        clearq(); shift = sh1[4:0];
        send_frame(2, d, 1'b1, 3);
        idle(6);
        check_outs("t5b", 2, e);
        clearq(); shift = sh2[4:0];
        send_frame(2, d2, 1'b1, 3);
        shift = 5'd0;
        send_frame(2, d, 1'b0, 2);
        idle(6);
        model_pool(d2, 6, 4, sh2, e);
        model_pool(d, 6, 4, sh2, d2);
        foreach (d2[i]) e.push_back(d2[i]);
        chk("t5c_count", q6d.size(), 12);
        for (int i = 0; i < 12 && i < q6d.size(); i++) begin
            chk($sformatf("t5c_data%0d", i), q6d[i], e[i]);
            chk($sformatf("t5c_fd%0d", i), int'(q6f[i]), (i == 5 || i == 11) ? 1 : 0);
        end

        // async reset while the first window is on the output
        clearq(); shift = 5'd4;
        for (int i = 0; i < 6; i++) px(1, 1600, i == 0);
        repeat (2) @(posedge sclk);
        #2;
        chk("t6_pre_ov", ov4, 1);
        s_rst_n = 1'b0;
        #1;
        chk("t6_ov", ov4, 0); chk("t6_od", od4, 0); chk("t6_fd", fd4, 0);
        idle(3);
        s_rst_n = 1'b1;
        idle(8);
        chk("t6_quiet", q4d.size(), 0);
        // after reset, pixels without sof count from (0,0) with shift 0
        clearq(); shift = 5'd4;
        d = '{100, 0, 0, 0};
        send_frame(0, d, 1'b0, 0);
        idle(5);
        e = '{100};
        check_outs("t6_nosof", 0, e);
        clearq(); shift = 5'd5;
        d.delete();
        for (int i = 0; i < 16; i++) d.push_back(int'($urandom_range(0, 6000)) - 1000);
        send_frame(1, d, 1'b1, 1);
        idle(6);
        model_pool(d, 4, 4, 5, e);
        check_outs("t6_new", 1, e);

        chk("fd_stray", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
